instr_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the core decode/execute stage.
//  - Owns the fetch PC and issues word reads to the synchronous instruction memory (1-cycle read latency).
//  - Buffers returned words with their PCs in a small prefetch FIFO.
//  - Presents them to decode over a valid/ready handshake.
//  - Redirects (branch/jump/reset vector) flush the buffer and all in-flight reads.

---
 rtl/core_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 40 ++++
 rtl/instr_fetch.sv | 71 +++++++
 tb/tb_instr_fetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared fetch widths, NOP encoding and the prefetch FIFO entry layout
package core_pkg;
  localparam int DEF_PC_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: pointer-based prefetch FIFO; flush overrides push and pop
module fetch_fifo import core_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 din,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop && count != '0;
    do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
    head = mem[rd_ptr];
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, 1-cycle IMem reads, prefetch FIFO, redirect flush.
// Define IFETCH_PERF_CNT_EN to add the saturating stall_cnt counter.
module instr_fetch import core_pkg::*; #(
  parameter int PC_W = DEF_PC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              nrst,
  output logic              imem_en,
  output logic [PC_W-3:0]   imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [PC_W-1:0]   instr_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH);
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
  } entry_t;
  entry_t head, din;
  logic [PC_W-1:0] fetch_pc, rd_pc;
  logic [CW:0] count;
  logic inflight, kill, push, pop;
  // credit check ignores a same-cycle pop so the FIFO can never overflow
  always_comb begin
    kill = redirect_valid;
    push = inflight && !kill;
    instr_valid = count != '0;
    pop = instr_valid && instr_ready;
    imem_en = nrst && !redirect_valid && ({1'b0, count} + (CW+2)'(inflight)) < (CW+2)'(DEPTH);
    imem_addr = fetch_pc[PC_W-1:2];
    din = '{pc: rd_pc, instr: imem_rdata};
    instr = instr_valid ? head.instr : DATA_W'(NOP);
    instr_pc = instr_valid ? head.pc : '0;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      fetch_pc <= RESET_PC;
      rd_pc <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) rd_pc <= fetch_pc;
      fetch_pc <= redirect_valid ? (redirect_pc & ~PC_W'(3)) : imem_en ? fetch_pc + PC_W'(4) : fetch_pc;
    end
  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk(clk),
    .nrst(nrst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din(din),
    .head(head),
    .count(count)
  );
`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) stall_cnt <= '0;
    else if (instr_ready && !instr_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a 1-cycle IMem model
module tb_instr_fetch;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic imem_en;
  logic [5:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic redirect_valid = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic instr_valid;
  logic instr_ready = 1'b1;
  logic [31:0] instr;
  logic [7:0] instr_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif
  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int issues;

  instr_fetch dut (
    .clk(clk),
    .nrst(nrst),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // IMem word at address a holds 0x1000_0000 + a
  always @(posedge clk) if (imem_en) imem_rdata <= 32'h1000_0000 | 32'(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_pop(input logic [7:0] pc, input logic [31:0] ins);
    sb.push_back('{pc: pc, ins: ins});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (nrst && instr_valid && instr_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %h want no entry", instr_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pop_pc", 32'(instr_pc), 32'(e.pc));
        check("pop_instr", instr, e.ins);
      end
    end

  initial begin
    #50000;
    n_bad++;
    $display("FAIL watchdog: got no finish want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_imem_en", 32'(imem_en), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", 32'(instr_pc), 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    // streaming with ready tied high
    for (int i = 0; i < 8; i++) expect_pop(8'(i * 4), 32'h1000_0000 + 32'(i));
    #1;
    check("c0_en", 32'(imem_en), 1);
    check("c0_addr", 32'(imem_addr), 0);
    check("c0_valid", 32'(instr_valid), 0);
    step(1);
    check("c1_addr", 32'(imem_addr), 1);
    check("c1_valid", 32'(instr_valid), 0);
    step(1);
    check("c2_addr", 32'(imem_addr), 2);
    check("c2_valid", 32'(instr_valid), 1);
`ifdef IFETCH_PERF_CNT_EN
    check("stall_after_start", 32'(stall_cnt), 2);
`endif
    step(8);
    // mid-stream asynchronous reset, 3ns low
    nrst = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("arst_en", 32'(imem_en), 0);
    check("arst_valid", 32'(instr_valid), 0);
    check("arst_instr", instr, 0);
    check("arst_pc", 32'(instr_pc), 0);
`ifdef IFETCH_PERF_CNT_EN
    check("arst_stall", 32'(stall_cnt), 0);
`endif
    #2;
    nrst = 1'b1;
    // backpressure: exactly DEPTH issues
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("restart_addr", 32'(imem_addr), 0);
      if (imem_en) issues++;
    end
    check("bp_issues", 32'(issues), 4);
    check("bp_en_idle", 32'(imem_en), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) expect_pop(8'(i * 4), 32'h1000_0000 + 32'(i));
    instr_ready = 1'b1;
    step(4);
    instr_ready = 1'b0;
    check("bp_drained", 32'(sb.size()), 0);
    step(3);
    // redirect to 0x43 while full
    redirect_valid = 1'b1;
    redirect_pc = 8'h43;
    #1;
    check("redir_no_issue", 32'(imem_en), 0);
    step(1);
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("redir_n1_valid", 32'(instr_valid), 0);
    check("redir_n1_en", 32'(imem_en), 1);
    check("redir_n1_addr", 32'(imem_addr), 32'h10);
    step(1);
    check("redir_n2_valid", 32'(instr_valid), 0);
    step(1);
    instr_ready = 1'b0;
    #1;
    check("redir_n3_valid", 32'(instr_valid), 1);
    check("redir_n3_pc", 32'(instr_pc), 32'h40);
    check("redir_n3_instr", instr, 32'h1000_0010);
`ifdef IFETCH_PERF_CNT_EN
    check("stall_after_redirect", 32'(stall_cnt), 2);
`endif
    step(3);
    // kill an in-flight read, then fetch across the 0xFC wrap
    expect_pop(8'h40, 32'h1000_0010);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    #1;
    check("kill_issue_addr", 32'(imem_addr), 32'h14);
    check("kill_issue_en", 32'(imem_en), 1);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc = 8'hF8;
    step(1);
    redirect_valid = 1'b0;
    #1;
    check("kill_valid", 32'(instr_valid), 0);
    check("kill_new_addr", 32'(imem_addr), 32'h3E);
    step(6);
    expect_pop(8'hF8, 32'h1000_003E);
    expect_pop(8'hFC, 32'h1000_003F);
    expect_pop(8'h00, 32'h1000_0000);
    expect_pop(8'h04, 32'h1000_0001);
    instr_ready = 1'b1;
    step(4);
    instr_ready = 1'b0;
    step(2);
`ifdef IFETCH_PERF_CNT_EN
    check("stall_final", 32'(stall_cnt), 2);
`endif
    check("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
